one_two_demux: RTL and testbench

- Stream demultiplexer that steers each accepted input beat to one of two output channels.
- Inverse of the team's 2:1 mux: one input stream fans out to two destinations chosen per beat by a select bit.
- Each output channel has its own small FIFO, so a stalled destination does not block traffic bound for the other channel.
- Sits between a single producer and two independent consumers in the lab datapath.

---
 rtl/one_two_demux.sv | 111 +++++++++++
 tb/tb_one_two_demux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/one_two_demux.sv
// One-to-two stream demultiplexer with a small FIFO per output channel.
// Define ONE_TWO_DEMUX_ALTERNATE_EN to steer beats round-robin instead of by in_sel.
module one_two_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out0_data,
  output logic                       out0_valid,
  input  logic                       out0_ready,
  output logic [WIDTH-1:0]           out1_data,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [$clog2(DEPTH+1)-1:0] out0_level,
  output logic [$clog2(DEPTH+1)-1:0] out1_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [LW-1:0]    lvl_q  [2];
  logic [LW-1:0]    lvl_d  [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       rdy;
  logic             tgt;

`ifdef ONE_TWO_DEMUX_ALTERNATE_EN
  logic tog_q;
  logic tog_d;

  assign tgt   = tog_q;
  assign tog_d = tog_q ^ (in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= tog_d;
  end
`else
  assign tgt = in_sel;
`endif

  assign rdy     = {out1_ready, out0_ready};
  assign full[0] = (lvl_q[0] == LW'(DEPTH));
  assign full[1] = (lvl_q[1] == LW'(DEPTH));

  // A full target refuses even if it is being popped this cycle.
  assign in_ready = !full[tgt];

  assign push[0] = in_valid & in_ready & !tgt;
  assign push[1] = in_valid & in_ready & tgt;
  assign pop[0]  = (lvl_q[0] != '0) & rdy[0];
  assign pop[1]  = (lvl_q[1] != '0) & rdy[1];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      lvl_d[c]  = lvl_q[c];
      if (push[c]) wptr_d[c] = wptr_q[c] + PW'(1);
      if (pop[c])  rptr_d[c] = rptr_q[c] + PW'(1);
      unique case ({push[c], pop[c]})
        2'b10:   lvl_d[c] = lvl_q[c] + LW'(1);
        2'b01:   lvl_d[c] = lvl_q[c] - LW'(1);
        default: lvl_d[c] = lvl_q[c];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        lvl_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        lvl_q[c]  <= lvl_d[c];
      end
    end
  end

  // Payload storage needs no reset; validity comes from the level.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= in_data;
    end
  end

  assign out0_data  = mem_q[0][rptr_q[0]];
  assign out1_data  = mem_q[1][rptr_q[1]];
  assign out0_valid = (lvl_q[0] != '0);
  assign out1_valid = (lvl_q[1] != '0);
  assign out0_level = lvl_q[0];
  assign out1_level = lvl_q[1];

endmodule

// File: tb/tb_one_two_demux.sv
// Bench for one_two_demux: directed plus random steps checked
// against per-channel queue model.
module tb_one_two_demux;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
  logic [LW-1:0]    out0_level;
  logic [LW-1:0]    out1_level;

  one_two_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out0_level(out0_level), .out1_level(out1_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  bit               tog_m = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_tgt(bit sel);
`ifdef ONE_TWO_DEMUX_ALTERNATE_EN
    return tog_m;
`else
    return sel;
`endif
  endfunction

  // One clock cycle: drive, check mid-cycle, advance model at edge.
  task automatic cyc(bit v, bit sel, logic [7:0] d, bit r0, bit r1);
    bit t;
    bit erdy;
    bit push;
    bit pop0;
    bit pop1;
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    t    = model_tgt(sel);
    erdy = t ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
    chk("out0_level", 32'(out0_level), 32'(q0.size()));
    chk("out1_level", 32'(out1_level), 32'(q1.size()));
    if (q0.size() > 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() > 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    push = v && erdy;
    pop0 = r0 && (q0.size() > 0);
    pop1 = r1 && (q1.size() > 0);
    @(posedge clk);
    #1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (push) begin
      if (t) q1.push_back(d);
      else   q0.push_back(d);
      tog_m = ~tog_m;
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    tog_m = 1'b0;
  endtask

  initial begin
    #100;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_level", 32'(out0_level), 32'd0);
    chk("rst_out1_level", 32'(out1_level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // routing
    cyc(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // backpressure isolation
    cyc(1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
`ifndef ONE_TWO_DEMUX_ALTERNATE_EN
    chk("bp_out1_level", 32'(out1_level), 32'd2);
    in_valid = 1'b1;
    in_sel   = 1'b1;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
`endif
    cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // full plus pop: push refused, retried next cycle
    cyc(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // streaming with wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef ONE_TWO_DEMUX_ALTERNATE_EN
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom),
          8'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) == 0));
    end

    // reset with beats buffered
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
    chk("pre_rst_levels", 32'(out0_level + out1_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("mid_rst_out0_level", 32'(out0_level), 32'd0);
    chk("mid_rst_out1_level", 32'(out1_level), 32'd0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 8'h6B, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
